// File: rtl/dispatch_stage_pkg.sv
// Shared definitions for the dispatch stage: internal op codes, target
// channels, RV32I opcode constants, ROB entry kinds and instruction fields.
package dispatch_stage_pkg;

    localparam int OP_W = 6;

    typedef enum logic [OP_W-1:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LUI, OP_AUIPC,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_NONE
    } op_e;

    typedef enum logic [1:0] {
        CH_ALU = 2'd0,
        CH_LSU = 2'd1,
        CH_BRU = 2'd2
    } chan_e;

    localparam logic [6:0] RV_OP     = 7'b0110011;
    localparam logic [6:0] RV_OP_IMM = 7'b0010011;
    localparam logic [6:0] RV_LUI    = 7'b0110111;
    localparam logic [6:0] RV_AUIPC  = 7'b0010111;
    localparam logic [6:0] RV_BRANCH = 7'b1100011;
    localparam logic [6:0] RV_JAL    = 7'b1101111;
    localparam logic [6:0] RV_JALR   = 7'b1100111;
    localparam logic [6:0] RV_LOAD   = 7'b0000011;
    localparam logic [6:0] RV_STORE  = 7'b0100011;

    localparam logic [1:0] ROB_KIND_BRANCH = 2'd1;
    localparam logic [1:0] ROB_KIND_STORE  = 2'd2;
    localparam logic [1:0] ROB_KIND_NORMAL = 2'd3;

    // Instruction field bit intervals
    localparam int OPC_LO = 0;
    localparam int OPC_HI = 6;
    localparam int RD_LO  = 7;
    localparam int RD_HI  = 11;
    localparam int F3_LO  = 12;
    localparam int F3_HI  = 14;
    localparam int RS1_LO = 15;
    localparam int RS1_HI = 19;
    localparam int RS2_LO = 20;
    localparam int RS2_HI = 24;
    localparam int F7_LO  = 25;
    localparam int F7_HI  = 31;

endpackage

// File: rtl/dispatch_decode.sv
// Combinational RV32I decoder: instruction word -> internal op, target
// channel, sign-extended immediate, operand usage and legality.
module dispatch_decode
    import dispatch_stage_pkg::*;
(
    input  logic [31:0] i_inst,
    output op_e         o_op,
    output chan_e       o_ch,
    output logic [31:0] o_imm,
    output logic        o_uses_rs1,
    output logic        o_uses_rs2,
    output logic        o_writes_rd,
    output logic [1:0]  o_rob_kind,
    output logic        o_legal
);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_opc   = i_inst[OPC_HI:OPC_LO];
    assign w_f3    = i_inst[F3_HI:F3_LO];
    assign w_f7    = i_inst[F7_HI:F7_LO];
    assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u = {i_inst[31:12], 12'd0};
    assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    // Decode opcode/funct fields into op, channel, immediate and operand usage
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_op        = OP_NONE;
        o_ch        = CH_ALU;
        o_imm       = '0;
        o_uses_rs1  = 1'b0;
        o_uses_rs2  = 1'b0;
        o_writes_rd = 1'b0;
        o_rob_kind  = ROB_KIND_NORMAL;
        o_legal     = 1'b1;
        case (w_opc)
            RV_OP: begin
                o_uses_rs1  = 1'b1;
                o_uses_rs2  = 1'b1;
                o_writes_rd = 1'b1;
                o_legal     = (w_f7 == 7'h00) || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5));
                case (w_f3)
                    3'd0:    o_op = w_f7[5] ? OP_SUB : OP_ADD;
                    3'd1:    o_op = OP_SLL;
                    3'd2:    o_op = OP_SLT;
                    3'd3:    o_op = OP_SLTU;
                    3'd4:    o_op = OP_XOR;
                    3'd5:    o_op = w_f7[5] ? OP_SRA : OP_SRL;
                    3'd6:    o_op = OP_OR;
                    default: o_op = OP_AND;
                endcase
            end
            RV_OP_IMM: begin
                o_uses_rs1  = 1'b1;
                o_writes_rd = 1'b1;
                o_imm       = w_imm_i;
                case (w_f3)
                    3'd0: o_op = OP_ADDI;
                    3'd1: begin
                        o_op    = OP_SLLI;
                        o_imm   = {27'd0, i_inst[24:20]};
                        o_legal = (w_f7 == 7'h00);
                    end
                    3'd2: o_op = OP_SLTI;
                    3'd3: o_op = OP_SLTIU;
                    3'd4: o_op = OP_XORI;
                    3'd5: begin
                        o_op    = w_f7[5] ? OP_SRAI : OP_SRLI;
                        o_imm   = {27'd0, i_inst[24:20]};
                        o_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
                    end
                    3'd6:    o_op = OP_ORI;
                    default: o_op = OP_ANDI;
                endcase
            end
            RV_LUI: begin
                o_op        = OP_LUI;
                o_writes_rd = 1'b1;
                o_imm       = w_imm_u;
            end
            RV_AUIPC: begin
                o_op        = OP_AUIPC;
                o_writes_rd = 1'b1;
                o_imm       = w_imm_u;
            end
            RV_BRANCH: begin
                o_ch       = CH_BRU;
                o_uses_rs1 = 1'b1;
                o_uses_rs2 = 1'b1;
                o_imm      = w_imm_b;
                o_rob_kind = ROB_KIND_BRANCH;
                case (w_f3)
                    3'd0:    o_op = OP_BEQ;
                    3'd1:    o_op = OP_BNE;
                    3'd4:    o_op = OP_BLT;
                    3'd5:    o_op = OP_BGE;
                    3'd6:    o_op = OP_BLTU;
                    3'd7:    o_op = OP_BGEU;
                    default: o_legal = 1'b0;
                endcase
            end
            RV_JAL: begin
                o_op        = OP_JAL;
                o_ch        = CH_BRU;
                o_writes_rd = 1'b1;
                o_imm       = w_imm_j;
            end
            RV_JALR: begin
                o_op        = OP_JALR;
                o_ch        = CH_BRU;
                o_uses_rs1  = 1'b1;
                o_writes_rd = 1'b1;
                o_imm       = w_imm_i;
                o_legal     = (w_f3 == 3'd0);
            end
            RV_LOAD: begin
                o_ch        = CH_LSU;
                o_uses_rs1  = 1'b1;
                o_writes_rd = 1'b1;
                o_imm       = w_imm_i;
                case (w_f3)
                    3'd0:    o_op = OP_LB;
                    3'd1:    o_op = OP_LH;
                    3'd2:    o_op = OP_LW;
                    3'd4:    o_op = OP_LBU;
                    3'd5:    o_op = OP_LHU;
                    default: o_legal = 1'b0;
                endcase
            end
            RV_STORE: begin
                o_ch       = CH_LSU;
                o_uses_rs1 = 1'b1;
                o_uses_rs2 = 1'b1;
                o_imm      = w_imm_s;
                o_rob_kind = ROB_KIND_STORE;
                case (w_f3)
                    3'd0:    o_op = OP_SB;
                    3'd1:    o_op = OP_SH;
                    3'd2:    o_op = OP_SW;
                    default: o_legal = 1'b0;
                endcase
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/dispatch_stage.sv
// Registered decode/rename/dispatch stage. Decodes one instruction per cycle,
// resolves operands from RF, ROB or the CDBs, allocates a ROB entry, renames
// rd and parks the packet in a one-entry holding register (H) until the
// target channel accepts it, waking pending operands from the CDBs meanwhile.
module dispatch_stage
    import dispatch_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int TAG_W  = 3,
    parameter int N_CDB  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    inst_valid,
    input  logic [31:0]             inst,
    input  logic [DATA_W-1:0]       inst_pc,
    output logic                    inst_ready,
    output logic [REG_W-1:0]        rf_name1,
    output logic [REG_W-1:0]        rf_name2,
    input  logic                    rf_busy1,
    input  logic                    rf_busy2,
    input  logic [TAG_W-1:0]        rf_tag1,
    input  logic [TAG_W-1:0]        rf_tag2,
    input  logic [DATA_W-1:0]       rf_data1,
    input  logic [DATA_W-1:0]       rf_data2,
    output logic [TAG_W-1:0]        rob_qtag1,
    output logic [TAG_W-1:0]        rob_qtag2,
    input  logic                    rob_qrdy1,
    input  logic                    rob_qrdy2,
    input  logic [DATA_W-1:0]       rob_qval1,
    input  logic [DATA_W-1:0]       rob_qval2,
    input  logic                    rob_full,
    input  logic [TAG_W-1:0]        rob_tail,
    output logic                    rob_alloc,
    output logic [1:0]              rob_kind,
    output logic [REG_W-1:0]        rob_rd,
    output logic [DATA_W-1:0]       rob_pc,
    output logic                    rn_we,
    output logic [REG_W-1:0]        rn_rd,
    input  logic [N_CDB-1:0]        cdb_valid,
    input  logic [N_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [N_CDB*DATA_W-1:0] cdb_data,
    output logic                    alu_valid,
    input  logic                    alu_ready,
    output logic                    lsu_valid,
    input  logic                    lsu_ready,
    output logic                    bru_valid,
    input  logic                    bru_ready,
    output logic [OP_W-1:0]         d_op,
    output logic                    d_busy1,
    output logic                    d_busy2,
    output logic [TAG_W-1:0]        d_tag1,
    output logic [TAG_W-1:0]        d_tag2,
    output logic [DATA_W-1:0]       d_val1,
    output logic [DATA_W-1:0]       d_val2,
    output logic [DATA_W-1:0]       d_imm,
    output logic [DATA_W-1:0]       d_pc,
    output logic [TAG_W-1:0]        d_rob,
    output logic                    illegal
);

    typedef struct packed {
        logic              busy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } opnd_t;

    // Priority: RF value, then ROB value, then same-cycle CDB, else pending.
    // Unused operands and x0 resolve to a ready zero.
    function automatic opnd_t resolve(
        input logic              used,
        input logic [REG_W-1:0]  idx,
        input logic              busy,
        input logic [TAG_W-1:0]  tag,
        input logic [DATA_W-1:0] data,
        input logic              qrdy,
        input logic [DATA_W-1:0] qval,
        input logic              hit,
        input logic [DATA_W-1:0] hval
    );
        opnd_t o;
        o = '0;
        if (used && idx != '0) begin
            if (!busy)     o.val = data;
            else if (qrdy) o.val = qval;
            else if (hit)  o.val = hval;
            else begin
                o.busy = 1'b1;
                o.tag  = tag;
            end
        end
        return o;
    endfunction

    // Decoder outputs
    op_e         w_op;
    chan_e       w_ch;
    logic [31:0] w_imm;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic        w_writes_rd;
    logic [1:0]  w_rob_kind;
    logic        w_legal;

    dispatch_decode u_decode (
        .i_inst      (inst),
        .o_op        (w_op),
        .o_ch        (w_ch),
        .o_imm       (w_imm),
        .o_uses_rs1  (w_uses_rs1),
        .o_uses_rs2  (w_uses_rs2),
        .o_writes_rd (w_writes_rd),
        .o_rob_kind  (w_rob_kind),
        .o_legal     (w_legal)
    );

    // Holding register H
    logic              r_valid;
    chan_e             r_ch;
    logic [OP_W-1:0]   r_op;
    logic              r_busy1;
    logic              r_busy2;
    logic [TAG_W-1:0]  r_tag1;
    logic [TAG_W-1:0]  r_tag2;
    logic [DATA_W-1:0] r_val1;
    logic [DATA_W-1:0] r_val2;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc;
    logic [TAG_W-1:0]  r_rob;

    logic [REG_W-1:0]  w_rd;
    logic              w_h_live;
    logic              w_ch_ready;
    logic              w_fire;
    logic              w_accept;
    logic              w_alloc;
    opnd_t             w_src1;
    opnd_t             w_src2;

    assign w_rd      = REG_W'(inst[RD_HI:RD_LO]);
    assign rf_name1  = REG_W'(inst[RS1_HI:RS1_LO]);
    assign rf_name2  = REG_W'(inst[RS2_HI:RS2_LO]);
    assign rob_qtag1 = rf_tag1;
    assign rob_qtag2 = rf_tag2;

    // CDB tag matches: accept-time operands (rf_tag) and waiting operands (H tags)
    logic [N_CDB-1:0] w_acc_hit1;
    logic [N_CDB-1:0] w_acc_hit2;
    logic [N_CDB-1:0] w_h_hit1;
    logic [N_CDB-1:0] w_h_hit2;

    for (genvar g = 0; g < N_CDB; g++) begin : g_cdb
        assign w_acc_hit1[g] = cdb_valid[g] && (cdb_tag[g*TAG_W +: TAG_W] == rf_tag1);
        assign w_acc_hit2[g] = cdb_valid[g] && (cdb_tag[g*TAG_W +: TAG_W] == rf_tag2);
        assign w_h_hit1[g]   = cdb_valid[g] && (cdb_tag[g*TAG_W +: TAG_W] == r_tag1);
        assign w_h_hit2[g]   = cdb_valid[g] && (cdb_tag[g*TAG_W +: TAG_W] == r_tag2);
    end

    logic [DATA_W-1:0] w_acc_cdb1;
    logic [DATA_W-1:0] w_acc_cdb2;
    logic [DATA_W-1:0] w_h_cdb1;
    logic [DATA_W-1:0] w_h_cdb2;

    // Pick the CDB data per match set; scanning downward lets the lowest bus win
    always_comb begin
        w_acc_cdb1 = '0;
        w_acc_cdb2 = '0;
        w_h_cdb1   = '0;
        w_h_cdb2   = '0;
        for (int i = N_CDB - 1; i >= 0; i--) begin
            if (w_acc_hit1[i]) w_acc_cdb1 = cdb_data[i*DATA_W +: DATA_W];
            if (w_acc_hit2[i]) w_acc_cdb2 = cdb_data[i*DATA_W +: DATA_W];
            if (w_h_hit1[i])   w_h_cdb1   = cdb_data[i*DATA_W +: DATA_W];
            if (w_h_hit2[i])   w_h_cdb2   = cdb_data[i*DATA_W +: DATA_W];
        end
    end

    // Ready of the channel H targets
    always_comb begin
        w_ch_ready = 1'b0;
        case (r_ch)
            CH_ALU:  w_ch_ready = alu_ready;
            CH_LSU:  w_ch_ready = lsu_ready;
            CH_BRU:  w_ch_ready = bru_ready;
            default: w_ch_ready = 1'b0;
        endcase
    end

    // Flush and reset hide H from the channels, so no handshake can complete
    assign w_h_live = r_valid && !flush && !rst;
    assign w_fire   = w_h_live && w_ch_ready;
    assign w_accept = inst_valid && !flush && !rst && !rob_full && (!r_valid || w_fire);
    assign w_alloc  = w_accept && w_legal;

    assign w_src1 = resolve(w_uses_rs1, rf_name1, rf_busy1, rf_tag1, rf_data1,
                            rob_qrdy1, rob_qval1, |w_acc_hit1, w_acc_cdb1);
    assign w_src2 = resolve(w_uses_rs2, rf_name2, rf_busy2, rf_tag2, rf_data2,
                            rob_qrdy2, rob_qval2, |w_acc_hit2, w_acc_cdb2);

    assign inst_ready = w_accept;
    assign illegal    = w_accept && !w_legal;
    assign rob_alloc  = w_alloc;
    assign rob_kind   = w_alloc ? w_rob_kind : 2'd0;
    assign rob_rd     = (w_alloc && w_writes_rd) ? w_rd : '0;
    assign rob_pc     = w_alloc ? inst_pc : '0;
    assign rn_we      = w_alloc && w_writes_rd && (w_rd != '0);
    assign rn_rd      = rn_we ? w_rd : '0;

    assign alu_valid = w_h_live && (r_ch == CH_ALU);
    assign lsu_valid = w_h_live && (r_ch == CH_LSU);
    assign bru_valid = w_h_live && (r_ch == CH_BRU);

    assign d_op    = r_op;
    assign d_busy1 = r_busy1;
    assign d_busy2 = r_busy2;
    assign d_tag1  = r_tag1;
    assign d_tag2  = r_tag2;
    assign d_val1  = r_val1;
    assign d_val2  = r_val2;
    assign d_imm   = r_imm;
    assign d_pc    = r_pc;
    assign d_rob   = r_rob;

    // H update: reset/flush kill, load on legal accept, drop on fire, else CDB wakeup
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_valid <= 1'b0;
            r_ch    <= CH_ALU;
            r_op    <= '0;
            r_busy1 <= 1'b0;
            r_busy2 <= 1'b0;
            r_tag1  <= '0;
            r_tag2  <= '0;
            r_val1  <= '0;
            r_val2  <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
            r_rob   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_alloc) begin
            r_valid <= 1'b1;
            r_ch    <= w_ch;
            r_op    <= w_op;
            r_busy1 <= w_src1.busy;
            r_tag1  <= w_src1.tag;
            r_val1  <= w_src1.val;
            r_busy2 <= w_src2.busy;
            r_tag2  <= w_src2.tag;
            r_val2  <= w_src2.val;
            r_imm   <= DATA_W'(w_imm);
            r_pc    <= inst_pc;
            r_rob   <= rob_tail;
        end else if (w_fire) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            if (r_busy1 && |w_h_hit1) begin
                r_busy1 <= 1'b0;
                r_val1  <= w_h_cdb1;
            end
            if (r_busy2 && |w_h_hit2) begin
                r_busy2 <= 1'b0;
                r_val2  <= w_h_cdb2;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed self-checking bench for dispatch_stage. Inputs change on the
// falling edge; outputs are checked 1 time unit later.
module tb_dispatch_stage;
    import dispatch_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [4:0]  rf_name1, rf_name2;
    logic        rf_busy1, rf_busy2;
    logic [2:0]  rf_tag1, rf_tag2;
    logic [31:0] rf_data1, rf_data2;
    logic [2:0]  rob_qtag1, rob_qtag2;
    logic        rob_qrdy1, rob_qrdy2;
    logic [31:0] rob_qval1, rob_qval2;
    logic        rob_full;
    logic [2:0]  rob_tail;
    logic        rob_alloc;
    logic [1:0]  rob_kind;
    logic [4:0]  rob_rd;
    logic [31:0] rob_pc;
    logic        rn_we;
    logic [4:0]  rn_rd;
    logic [1:0]  cdb_valid;
    logic [5:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic        alu_valid, alu_ready;
    logic        lsu_valid, lsu_ready;
    logic        bru_valid, bru_ready;
    logic [5:0]  d_op;
    logic        d_busy1, d_busy2;
    logic [2:0]  d_tag1, d_tag2;
    logic [31:0] d_val1, d_val2;
    logic [31:0] d_imm;
    logic [31:0] d_pc;
    logic [2:0]  d_rob;
    logic        illegal;

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [31:0] ADD_X3 = 32'h002081B3;  // add x3, x1, x2
    localparam logic [31:0] LW_X5  = 32'h00832283;  // lw  x5, 8(x6)
    localparam logic [31:0] BEQ_8  = 32'h00208463;  // beq x1, x2, +8
    localparam logic [31:0] BAD_OP = 32'h0000007F;

    dispatch_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .rf_name1(rf_name1), .rf_name2(rf_name2),
        .rf_busy1(rf_busy1), .rf_busy2(rf_busy2),
        .rf_tag1(rf_tag1), .rf_tag2(rf_tag2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .rob_qtag1(rob_qtag1), .rob_qtag2(rob_qtag2),
        .rob_qrdy1(rob_qrdy1), .rob_qrdy2(rob_qrdy2),
        .rob_qval1(rob_qval1), .rob_qval2(rob_qval2),
        .rob_full(rob_full), .rob_tail(rob_tail),
        .rob_alloc(rob_alloc), .rob_kind(rob_kind), .rob_rd(rob_rd), .rob_pc(rob_pc),
        .rn_we(rn_we), .rn_rd(rn_rd),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .bru_valid(bru_valid), .bru_ready(bru_ready),
        .d_op(d_op), .d_busy1(d_busy1), .d_busy2(d_busy2),
        .d_tag1(d_tag1), .d_tag2(d_tag2), .d_val1(d_val1), .d_val2(d_val2),
        .d_imm(d_imm), .d_pc(d_pc), .d_rob(d_rob), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'd0, rd, 7'h13};
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        inst_valid = 1'b1; inst = addi(5'd1, 12'd5); inst_pc = 32'h0;
        rf_busy1 = 1'b0; rf_busy2 = 1'b0; rf_tag1 = 3'd0; rf_tag2 = 3'd0;
        rf_data1 = 32'h0; rf_data2 = 32'h0;
        rob_qrdy1 = 1'b0; rob_qrdy2 = 1'b0; rob_qval1 = 32'h0; rob_qval2 = 32'h0;
        rob_full = 1'b0; rob_tail = 3'd0;
        cdb_valid = 2'b00; cdb_tag = 6'd0; cdb_data = 64'd0;
        alu_ready = 1'b1; lsu_ready = 1'b1; bru_ready = 1'b1;

        // Reset state
        next(); #1;
        check1("rst_inst_ready", inst_ready, 1'b0);
        check1("rst_rob_alloc", rob_alloc, 1'b0);
        check1("rst_rn_we", rn_we, 1'b0);
        check1("rst_illegal", illegal, 1'b0);
        check1("rst_alu_valid", alu_valid, 1'b0);
        check1("rst_lsu_valid", lsu_valid, 1'b0);
        check1("rst_bru_valid", bru_valid, 1'b0);
        check32("rst_d_rob", 32'(d_rob), 32'd0);
        check32("rst_d_imm", d_imm, 32'd0);

        // 1. addi x1,x0,5 (rf_data1 junk must not leak through x0)
        next(); rst = 1'b0; inst_pc = 32'h100; rob_tail = 3'd3; rf_data1 = 32'hDEAD; #1;
        check1("t1_inst_ready", inst_ready, 1'b1);
        check1("t1_rob_alloc", rob_alloc, 1'b1);
        check1("t1_rn_we", rn_we, 1'b1);
        check32("t1_rn_rd", 32'(rn_rd), 32'd1);
        check32("t1_rob_kind", 32'(rob_kind), 32'd3);
        check32("t1_rob_pc", rob_pc, 32'h100);
        next(); inst_valid = 1'b0; #1;
        check1("t1_alu_valid", alu_valid, 1'b1);
        check1("t1_lsu_valid", lsu_valid, 1'b0);
        check1("t1_bru_valid", bru_valid, 1'b0);
        check32("t1_d_op", 32'(d_op), 32'(OP_ADDI));
        check1("t1_d_busy1", d_busy1, 1'b0);
        check32("t1_d_val1", d_val1, 32'd0);
        check32("t1_d_imm", d_imm, 32'd5);
        check32("t1_d_rob", 32'(d_rob), 32'd3);
        check32("t1_d_pc", d_pc, 32'h100);

        // 2. add x3,x1,x2 with x1 pending on tag 2; ALU stalled; CDB wakeup
        next(); inst_valid = 1'b1; inst = ADD_X3; rf_busy1 = 1'b1; rf_tag1 = 3'd2;
        rf_data2 = 32'h22; rob_tail = 3'd4; alu_ready = 1'b0; #1;
        check1("t2_alu_drained", alu_valid, 1'b0);
        check1("t2_inst_ready", inst_ready, 1'b1);
        check32("t2_rob_qtag1", 32'(rob_qtag1), 32'd2);
        check32("t2_rn_rd", 32'(rn_rd), 32'd3);
        next(); inst = addi(5'd4, 12'd7); rob_tail = 3'd5;
        cdb_valid = 2'b11; cdb_tag = {3'd2, 3'd5}; cdb_data = {32'h77, 32'h55}; #1;
        check1("t2_alu_valid", alu_valid, 1'b1);
        check1("t2_d_busy1", d_busy1, 1'b1);
        check32("t2_d_tag1", 32'(d_tag1), 32'd2);
        check32("t2_d_val1_pending", d_val1, 32'd0);
        check1("t2_d_busy2", d_busy2, 1'b0);
        check32("t2_d_val2", d_val2, 32'h22);
        check32("t2_d_rob", 32'(d_rob), 32'd4);
        check1("t2_stall_ready", inst_ready, 1'b0);
        check1("t2_stall_alloc", rob_alloc, 1'b0);
        next(); cdb_valid = 2'b00; #1;
        check1("t2_woken_busy1", d_busy1, 1'b0);
        check32("t2_woken_val1", d_val1, 32'h77);
        check1("t2_still_stalled", inst_ready, 1'b0);
        alu_ready = 1'b1; rf_busy1 = 1'b0; #1;
        check1("t2_release_ready", inst_ready, 1'b1);
        check32("t2_release_rn_rd", 32'(rn_rd), 32'd4);
        next(); inst_valid = 1'b0; #1;
        check1("t2_next_alu_valid", alu_valid, 1'b1);
        check32("t2_next_d_imm", d_imm, 32'd7);
        check32("t2_next_d_rob", 32'(d_rob), 32'd5);

        // 3. lw with rs1 pending on tag 4, both buses broadcast tag 4 this cycle
        next(); inst_valid = 1'b1; inst = LW_X5; rf_busy1 = 1'b1; rf_tag1 = 3'd4; rob_tail = 3'd6;
        cdb_valid = 2'b11; cdb_tag = {3'd4, 3'd4}; cdb_data = {32'h999, 32'h100}; #1;
        check1("t3_inst_ready", inst_ready, 1'b1);
        check32("t3_rn_rd", 32'(rn_rd), 32'd5);
        next(); inst_valid = 1'b0; cdb_valid = 2'b00; rf_busy1 = 1'b0; #1;
        check1("t3_lsu_valid", lsu_valid, 1'b1);
        check1("t3_alu_valid", alu_valid, 1'b0);
        check1("t3_d_busy1", d_busy1, 1'b0);
        check32("t3_d_val1", d_val1, 32'h100);
        check32("t3_d_imm", d_imm, 32'd8);
        check32("t3_d_val2_unused", d_val2, 32'd0);
        check32("t3_d_op", 32'(d_op), 32'(OP_LW));
        check32("t3_d_rob", 32'(d_rob), 32'd6);

        // 4. ROB full blocks acceptance
        next(); inst_valid = 1'b1; inst = addi(5'd6, 12'd9); rob_full = 1'b1; rob_tail = 3'd7; #1;
        check1("t4_full_ready", inst_ready, 1'b0);
        check1("t4_full_alloc", rob_alloc, 1'b0);
        check1("t4_lsu_drained", lsu_valid, 1'b0);
        next(); #1;
        check1("t4_h_unchanged", alu_valid, 1'b0);
        rob_full = 1'b0; #1;
        check1("t4_release_ready", inst_ready, 1'b1);
        check1("t4_release_alloc", rob_alloc, 1'b1);
        next(); inst_valid = 1'b0; #1;
        check1("t4_alu_valid", alu_valid, 1'b1);
        check32("t4_d_imm", d_imm, 32'd9);
        check32("t4_d_rob", 32'(d_rob), 32'd7);

        // 5. beq held, then flush, then an unsupported opcode
        next(); inst_valid = 1'b1; inst = BEQ_8; rf_data1 = 32'h11; rf_data2 = 32'h22;
        rob_tail = 3'd0; bru_ready = 1'b0; #1;
        check1("t5_inst_ready", inst_ready, 1'b1);
        check32("t5_rob_kind", 32'(rob_kind), 32'd1);
        check32("t5_rob_rd", 32'(rob_rd), 32'd0);
        check1("t5_rn_we", rn_we, 1'b0);
        next(); inst_valid = 1'b0; #1;
        check1("t5_bru_valid", bru_valid, 1'b1);
        check32("t5_d_val1", d_val1, 32'h11);
        check32("t5_d_val2", d_val2, 32'h22);
        check32("t5_d_imm", d_imm, 32'd8);
        check32("t5_d_op", 32'(d_op), 32'(OP_BEQ));
        flush = 1'b1; bru_ready = 1'b1; inst_valid = 1'b1; inst = addi(5'd7, 12'd1); #1;
        check1("t5_flush_bru", bru_valid, 1'b0);
        check1("t5_flush_ready", inst_ready, 1'b0);
        check1("t5_flush_alloc", rob_alloc, 1'b0);
        next(); flush = 1'b0; inst = BAD_OP; #1;
        check1("t5_after_flush_bru", bru_valid, 1'b0);
        check1("t5_bad_ready", inst_ready, 1'b1);
        check1("t5_bad_illegal", illegal, 1'b1);
        check1("t5_bad_alloc", rob_alloc, 1'b0);
        check1("t5_bad_rn_we", rn_we, 1'b0);
        next(); inst_valid = 1'b0; #1;
        check1("t5_illegal_pulse_end", illegal, 1'b0);
        check1("t5_h_empty_alu", alu_valid, 1'b0);
        check1("t5_h_empty_lsu", lsu_valid, 1'b0);
        check1("t5_h_empty_bru", bru_valid, 1'b0);

        // 6. Back-to-back stream of four addi
        for (int k = 0; k < 4; k++) begin
            next(); inst_valid = 1'b1; inst = addi(5'(10 + k), 12'(k + 1)); rob_tail = 3'(k + 1); #1;
            check1("t6_inst_ready", inst_ready, 1'b1);
            check1("t6_rob_alloc", rob_alloc, 1'b1);
            if (k > 0) begin
                check1("t6_alu_valid", alu_valid, 1'b1);
                check32("t6_d_rob", 32'(d_rob), 32'(k));
                check32("t6_d_imm", d_imm, 32'(k));
            end
        end
        next(); inst_valid = 1'b0; #1;
        check1("t6_last_alu_valid", alu_valid, 1'b1);
        check32("t6_last_d_rob", 32'(d_rob), 32'd4);
        check32("t6_last_d_imm", d_imm, 32'd4);

        // 7. Reset while H holds a stalled packet
        next(); alu_ready = 1'b0; inst_valid = 1'b1; inst = addi(5'd8, 12'd3); rob_tail = 3'd5; #1;
        check1("t7_drained", alu_valid, 1'b0);
        check1("t7_inst_ready", inst_ready, 1'b1);
        next(); inst_valid = 1'b0; #1;
        check1("t7_held", alu_valid, 1'b1);
        rst = 1'b1; #1;
        check1("t7_rst_hides_valid", alu_valid, 1'b0);
        next(); rst = 1'b0; #1;
        check1("t7_after_rst_valid", alu_valid, 1'b0);
        check32("t7_after_rst_d_rob", 32'(d_rob), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
